// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: squarer state encoding, default operand/result
// widths and the golden squaring function used by benches.
package arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } sq_state_t;

   localparam int SQ_IN_W  = 12;
   localparam int SQ_OUT_W = 24;

   function automatic logic [2*SQ_IN_W-1:0] sq_ref(input logic [SQ_IN_W-1:0] a);
      logic [2*SQ_IN_W-1:0] a_ext;
      a_ext  = {{SQ_IN_W{1'b0}}, a};
      sq_ref = a_ext * a_ext;
   endfunction

endpackage

// File: rtl/square_unit_if.sv
// Request/result bundle of square_unit. Port ovf exists only when SQUARE_SAT_EN
// is defined.
interface square_unit_if
   import arith_pkg::*;
#(
   parameter int IN_W  = SQ_IN_W,
   parameter int OUT_W = SQ_OUT_W
);
   logic             start;
   logic [IN_W-1:0]  A;
   logic             ready;
   logic             done;
   logic [OUT_W-1:0] Q;
`ifdef SQUARE_SAT_EN
   logic             ovf;
`endif

   modport master (
      output start, A,
`ifdef SQUARE_SAT_EN
      input  ovf,
`endif
      input  ready, done, Q
   );

   modport slave (
      input  start, A,
`ifdef SQUARE_SAT_EN
      output ovf,
`endif
      output ready, done, Q
   );
endinterface

// File: rtl/square_unit.sv
// Iterative radix-2 shift-add squarer (Q = A*A), fixed IN_W iterations.
// SQUARE_SAT_EN selects saturation with an ovf flag instead of truncation.
module square_unit
   import arith_pkg::*;
#(
   parameter int IN_W  = SQ_IN_W,
   parameter int OUT_W = SQ_OUT_W
) (
   input  logic          clk,
   input  logic          rst_,
   square_unit_if.slave  bus
);

   localparam int ACC_W = 2 * IN_W;
   localparam int CNT_W = $clog2(IN_W + 1);
   localparam logic [ACC_W-1:0] Q_MAX  = ACC_W'({OUT_W{1'b1}});
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

   sq_state_t        state_q, state_d;
   logic [ACC_W-1:0] m_q, m_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [IN_W-1:0]  b_q, b_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
   logic [OUT_W-1:0] q_q, q_d;
   logic             ovf_q, ovf_d;

   // Next-state, datapath and output-register computation
   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      acc_d   = acc_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      q_d     = q_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (bus.start && ready_q) begin
               m_d     = {{IN_W{1'b0}}, bus.A};
               b_d     = bus.A;
               acc_d   = {ACC_W{1'b0}};
               cnt_d   = {CNT_W{1'b0}};
               state_d = CALC;
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            if (b_q[0]) begin
               acc_d = acc_q + m_q;
            end else begin
               acc_d = acc_q;
            end
            m_d   = m_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end else begin
               state_d = CALC;
            end
         end
         DONE: begin
`ifdef SQUARE_SAT_EN
            if (acc_q > Q_MAX) begin
               q_d   = {OUT_W{1'b1}};
               ovf_d = 1'b1;
            end else begin
               q_d   = OUT_W'(acc_q);
               ovf_d = 1'b0;
            end
`else
            q_d   = OUT_W'(acc_q);
            ovf_d = 1'b0;
`endif
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      ready_d = (state_d == IDLE);
   end

   // State and output registers; synchronous reset aborts any calculation
   always_ff @(posedge clk) begin
      if (rst_) begin
         state_q <= IDLE;
         m_q     <= {ACC_W{1'b0}};
         acc_q   <= {ACC_W{1'b0}};
         b_q     <= {IN_W{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         q_q     <= {OUT_W{1'b0}};
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         q_q     <= q_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.ready = ready_q;
   assign bus.done  = done_q;
   assign bus.Q     = q_q;
`ifdef SQUARE_SAT_EN
   assign bus.ovf   = ovf_q;
`else
   logic unused_ovf_s;
   assign unused_ovf_s = ovf_q;
`endif

endmodule

// File: tb/tb_square_unit.sv
// Directed bench for square_unit: a 12x24 instance and a 12x12 instance share
// the same stimulus; the narrow one exercises truncation or SQUARE_SAT_EN.
module tb_square_unit;
   import arith_pkg::*;

   logic        clk;
   logic        rst_;
   logic        start_s;
   logic [11:0] a_s;
   int          chk_cnt;
   int          err_cnt;

   square_unit_if #(.IN_W(12), .OUT_W(24)) bus24 ();
   square_unit_if #(.IN_W(12), .OUT_W(12)) bus12 ();

   assign bus24.start = start_s;
   assign bus24.A     = a_s;
   assign bus12.start = start_s;
   assign bus12.A     = a_s;

   square_unit #(.IN_W(12), .OUT_W(24)) dut24 (.clk(clk), .rst_(rst_), .bus(bus24.slave));
   square_unit #(.IN_W(12), .OUT_W(12)) dut12 (.clk(clk), .rst_(rst_), .bus(bus12.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected narrow-instance result derived from the full square
   function automatic logic [11:0] exp12(input logic [23:0] sq);
`ifdef SQUARE_SAT_EN
      exp12 = (sq > 24'h000FFF) ? 12'hFFF : sq[11:0];
`else
      exp12 = sq[11:0];
`endif
   endfunction

   function automatic logic exp_ovf12(input logic [23:0] sq);
`ifdef SQUARE_SAT_EN
      exp_ovf12 = (sq > 24'h000FFF);
`else
      exp_ovf12 = 1'b0;
`endif
   endfunction

   // Count edges until the wide instance pulses done (bounded)
   task automatic wait_done(output int n);
      logic got;
      got = 1'b0;
      n   = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clk); #1;
         n++;
         if (bus24.done) got = 1'b1;
      end
   endtask

   task automatic count_done(input int cycles, output int pulses);
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (bus24.done || bus12.done) pulses++;
      end
   endtask

   task automatic do_op(input string tag, input logic [11:0] a, input logic [23:0] sq);
      int n;
      check_val({tag, "_ready_pre"}, 32'(bus24.ready), 32'd1);
      start_s = 1'b1;
      a_s     = a;
      @(posedge clk); #1;
      start_s = 1'b0;
      a_s     = ~a;
      check_val({tag, "_ready_busy"}, 32'(bus24.ready), 32'd0);
      wait_done(n);
      check_val({tag, "_latency"}, 32'(n), 32'd13);
      check_val({tag, "_q24"}, 32'(bus24.Q), 32'(sq));
      check_val({tag, "_done12"}, 32'(bus12.done), 32'd1);
      check_val({tag, "_q12"}, 32'(bus12.Q), 32'(exp12(sq)));
`ifdef SQUARE_SAT_EN
      check_val({tag, "_ovf12"}, 32'(bus12.ovf), 32'(exp_ovf12(sq)));
      check_val({tag, "_ovf24"}, 32'(bus24.ovf), 32'd0);
`endif
      @(posedge clk); #1;
      check_val({tag, "_done_pulse"}, 32'(bus24.done), 32'd0);
   endtask

   initial begin
      int n;
      int pulses;
      chk_cnt = 0;
      err_cnt = 0;
      rst_    = 1'b1;
      start_s = 1'b0;
      a_s     = 12'h000;

      // 1: reset state and idle quiet period
      repeat (3) @(posedge clk);
      #1 rst_ = 1'b0;
      check_val("rst_ready", 32'(bus24.ready), 32'd1);
      check_val("rst_done", 32'(bus24.done), 32'd0);
      check_val("rst_q", 32'(bus24.Q), 32'd0);
      count_done(20, pulses);
      check_val("idle_no_done", 32'(pulses), 32'd0);

      // 2: basic operation and hold
      do_op("a010", 12'h010, 24'h000100);
      repeat (20) @(posedge clk);
      #1 check_val("a010_hold", 32'(bus24.Q), 32'h000100);

      // 3: extremes
      do_op("afff", 12'hFFF, 24'hFFE001);
      do_op("a000", 12'h000, 24'h000000);
      do_op("a001", 12'h001, 24'h000001);

      // 4: start held high, A changes during CALC
      start_s = 1'b1;
      a_s     = 12'h690;
      @(posedge clk); #1;
      a_s = 12'h123;
      wait_done(n);
      check_val("held_lat1", 32'(n), 32'd13);
      check_val("held_q1", 32'(bus24.Q), 32'h2B1100);
      wait_done(n);
      start_s = 1'b0;
      check_val("held_ii", 32'(n), 32'd14);
      check_val("held_q2", 32'(bus24.Q), 32'h014AC9);
      @(posedge clk); #1;

      // 5: reset mid-calculation
      start_s = 1'b1;
      a_s     = 12'h100;
      @(posedge clk); #1;
      start_s = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_ = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_ = 1'b0;
      check_val("abort_q", 32'(bus24.Q), 32'd0);
      check_val("abort_done", 32'(bus24.done), 32'd0);
      @(posedge clk); #1;
      check_val("abort_ready", 32'(bus24.ready), 32'd1);
      count_done(20, pulses);
      check_val("abort_no_done", 32'(pulses), 32'd0);
      do_op("a100", 12'h100, 24'h010000);

      // 6: narrow result path (saturate or truncate) on the 12-bit instance
      do_op("a03f", 12'h03F, 24'h000F81);

      $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
      $finish;
   end

endmodule
